core_sequencer: RTL and testbench

- Central multi-cycle control FSM for the scalar core. It replaces the ad hoc fetch/exec/write/load mode register.
- Issues one-cycle enables to the fetch, exec, reg-write, data-memory and FPU stages.
- Absorbs parameterised BRAM latencies and a variable-latency FPU done handshake.
- Provides run/halt control at instruction boundaries and a retired-instruction counter.

---
 rtl/core_sequencer.sv | 179 +++++++++++++++++
 tb/tb_core_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/exec/load/fpu/store/write control FSM with run/halt and retire count.
// Optional FPU watchdog is compiled in when SEQ_FPU_TIMEOUT_EN is defined.
module core_sequencer #(
    parameter int unsigned FETCH_LAT   = 1,
    parameter int unsigned LOAD_LAT    = 2,
    parameter int unsigned FPU_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        run,
    input  logic        halt_req,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic        ex_fpu,
    input  logic        ex_wb,
    input  logic        fpu_done,
    output logic        fetch_en,
    output logic        exec_en,
    output logic        mem_we,
    output logic        fpu_start,
    output logic        wb_en,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        busy,
    output logic        err,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_LOAD  = 3'd3,
        S_FPU   = 3'd4,
        S_STORE = 3'd5,
        S_WRITE = 3'd6,
        S_HALT  = 3'd7
    } state_e;

    // One shared latency counter, sized to also cover the FPU watchdog limit.
    localparam int unsigned MAX_LAT = (FETCH_LAT > LOAD_LAT) ? FETCH_LAT : LOAD_LAT;
    localparam int unsigned MAX_CNT = (FPU_TIMEOUT > MAX_LAT) ? FPU_TIMEOUT : MAX_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_LAT - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_LAT - 1);
`ifdef SEQ_FPU_TIMEOUT_EN
    localparam logic [CNT_W-1:0] FPU_LAST   = CNT_W'(FPU_TIMEOUT - 1);
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic             halt_pend_q, halt_pend_d;
    logic             err_q, err_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic             wb_pend_q, wb_pend_d;
    logic             fpu_first_q, fpu_first_d;
    logic             boundary;
    logic             multi_op;

    assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
    assign multi_op = (ex_load & ex_fpu) | (ex_load & ex_store) | (ex_fpu & ex_store);

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        halt_pend_d = halt_pend_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        wb_sel_d    = wb_sel_q;
        wb_pend_d   = wb_pend_q;
        fpu_first_d = 1'b0;
        boundary    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_HALT: begin
                if (run && !halt_req) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (lat_q == FETCH_LAST) begin
                    lat_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_EXEC: begin
                if (ex_load) begin
                    state_d   = S_LOAD;
                    wb_sel_d  = 2'd1;
                    wb_pend_d = 1'b1;
                end else if (ex_fpu) begin
                    state_d     = S_FPU;
                    wb_sel_d    = 2'd2;
                    wb_pend_d   = 1'b1;
                    fpu_first_d = 1'b1;
                end else begin
                    state_d   = ex_store ? S_STORE : S_WRITE;
                    wb_sel_d  = 2'd0;
                    wb_pend_d = ex_wb;
                end
                if (multi_op) err_d = 1'b1;
            end
            S_LOAD: begin
                if (lat_q == LOAD_LAST) begin
                    lat_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_FPU: begin
                // fpu_done coinciding with the launch cycle belongs to nothing we issued.
                if (!fpu_first_q && fpu_done) begin
                    lat_d   = '0;
                    state_d = S_WRITE;
                end
`ifdef SEQ_FPU_TIMEOUT_EN
                else if (lat_q == FPU_LAST) begin
                    lat_d     = '0;
                    state_d   = S_WRITE;
                    err_d     = 1'b1;
                    wb_pend_d = 1'b0;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
`endif
            end
            S_STORE: boundary = 1'b1;
            S_WRITE: boundary = 1'b1;
            default: state_d = S_IDLE;
        endcase

        if (busy && !boundary) halt_pend_d = halt_pend_q | halt_req;

        if (boundary) begin
            cnt_d       = cnt_q + 32'd1;
            halt_pend_d = 1'b0;
            state_d     = (halt_pend_q || halt_req) ? S_HALT : S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            halt_pend_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            wb_sel_q    <= 2'd0;
            wb_pend_q   <= 1'b0;
            fpu_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            halt_pend_q <= halt_pend_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            wb_sel_q    <= wb_sel_d;
            wb_pend_q   <= wb_pend_d;
            fpu_first_q <= fpu_first_d;
        end
    end

    assign state     = state_q;
    assign fetch_en  = (state_q == S_FETCH) && (lat_q == FETCH_LAST);
    assign exec_en   = (state_q == S_EXEC);
    assign mem_we    = (state_q == S_STORE);
    assign fpu_start = (state_q == S_FPU) && fpu_first_q;
    assign wb_en     = (state_q == S_WRITE) && wb_pend_q;
    assign wb_sel    = wb_sel_q;
    assign err       = err_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: instruction-level trace model, vector table and random stream.
module tb_core_sequencer;

    localparam int FETCH_LAT   = 1;
    localparam int LOAD_LAT    = 2;
    localparam int FPU_TIMEOUT = 255;

    localparam int S_IDLE  = 0;
    localparam int S_FETCH = 1;
    localparam int S_EXEC  = 2;
    localparam int S_LOAD  = 3;
    localparam int S_FPU   = 4;
    localparam int S_STORE = 5;
    localparam int S_WRITE = 6;
    localparam int S_HALT  = 7;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        run = 1'b0;
    logic        halt_req = 1'b0;
    logic        ex_load = 1'b0;
    logic        ex_store = 1'b0;
    logic        ex_fpu = 1'b0;
    logic        ex_wb = 1'b0;
    logic        fpu_done = 1'b0;
    logic        fetch_en, exec_en, mem_we, fpu_start, wb_en, busy, err;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    core_sequencer #(
        .FETCH_LAT  (FETCH_LAT),
        .LOAD_LAT   (LOAD_LAT),
        .FPU_TIMEOUT(FPU_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .run       (run),
        .halt_req  (halt_req),
        .ex_load   (ex_load),
        .ex_store  (ex_store),
        .ex_fpu    (ex_fpu),
        .ex_wb     (ex_wb),
        .fpu_done  (fpu_done),
        .fetch_en  (fetch_en),
        .exec_en   (exec_en),
        .mem_we    (mem_we),
        .fpu_start (fpu_start),
        .wb_en     (wb_en),
        .wb_sel    (wb_sel),
        .state     (state),
        .busy      (busy),
        .err       (err),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycles = 0;
    logic [31:0] exp_cnt = '0;
    logic        exp_err = 1'b0;
    logic [1:0]  exp_sel = 2'd0;

    typedef struct {
        string name;
        bit    ld, fp, st, wb;
        int    dly;
        bit    stray;
        int    halt_at;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    function automatic logic [43:0] reset_view();
        return {state, fetch_en, exec_en, fpu_start, mem_we, wb_en, busy, wb_sel, err, instr_cnt};
    endfunction

    // Builds the expected per-cycle state trace of one instruction from the sequencing rules,
    // then drives it and compares every cycle. Starts and ends with the DUT in FETCH.
    task automatic run_instr(input string name, input bit ld, input bit fp, input bit st, input bit wb,
                             input int dly, input bit stray, input int halt_at, input bit to);
        int         tr[$];
        int         fpu_at;
        int         nfpu;
        bit         pend;
        bit         halted;
        logic [11:0] act;
        logic [11:0] exp;
        fpu_at = FETCH_LAT + 1;
        nfpu   = to ? FPU_TIMEOUT : dly + 1;
        for (int i = 0; i < FETCH_LAT; i++) tr.push_back(S_FETCH);
        tr.push_back(S_EXEC);
        if (ld) begin
            for (int i = 0; i < LOAD_LAT; i++) tr.push_back(S_LOAD);
            tr.push_back(S_WRITE);
        end else if (fp) begin
            for (int i = 0; i < nfpu; i++) tr.push_back(S_FPU);
            tr.push_back(S_WRITE);
        end else if (st) begin
            tr.push_back(S_STORE);
        end else begin
            tr.push_back(S_WRITE);
        end
        pend   = (fp && !ld && to) ? 1'b0 : (ld | fp | wb);
        halted = (halt_at >= 0) && (halt_at < tr.size());
        ex_load = ld; ex_fpu = fp; ex_store = st; ex_wb = wb;
        for (int i = 0; i < tr.size(); i++) begin
            fpu_done = (fp && !ld && !to && i == fpu_at + dly) || (stray && (tr[i] == S_EXEC || i == fpu_at));
            halt_req = (i == halt_at);
            exp = {3'(tr[i]), i == FETCH_LAT - 1, tr[i] == S_EXEC, tr[i] == S_FPU && i == fpu_at,
                   tr[i] == S_STORE, tr[i] == S_WRITE && pend, 1'b1, exp_sel, exp_err};
            act = {state, fetch_en, exec_en, fpu_start, mem_we, wb_en, busy, wb_sel, err};
            check($sformatf("%s cyc%0d {st,fe,ex,fs,we,wb,busy,sel,err}", name, i), 64'(act), 64'(exp));
            tick();
            if (tr[i] == S_EXEC) begin
                exp_sel = ld ? 2'd1 : fp ? 2'd2 : 2'd0;
                if ((ld & fp) | (ld & st) | (fp & st)) exp_err = 1'b1;
            end
            if (to && tr[i] == S_FPU && i == fpu_at + nfpu - 1) exp_err = 1'b1;
        end
        fpu_done = 1'b0; halt_req = 1'b0;
        ex_load = 1'b0; ex_fpu = 1'b0; ex_store = 1'b0; ex_wb = 1'b0;
        exp_cnt++;
        check($sformatf("%s instr_cnt", name), 64'(instr_cnt), 64'(exp_cnt));
        if (halted) begin
            check($sformatf("%s halt {state,busy}", name), 64'({state, busy}), 64'({3'(S_HALT), 1'b0}));
            run = 1'b0;
            tick();
            check($sformatf("%s halt hold", name), 64'(state), 64'(S_HALT));
            run = 1'b1; halt_req = 1'b1;
            tick();
            check($sformatf("%s halt run+req", name), 64'(state), 64'(S_HALT));
            halt_req = 1'b0;
            tick();
        end
        check($sformatf("%s next", name), 64'(state), 64'(S_FETCH));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   c0;
        bit   r_ld, r_fp, r_st, r_wb;
        int   r_dly, r_halt;

        vecs[0] = '{"alu_wb",        0, 0, 0, 1, 1, 0, -1};
        vecs[1] = '{"alu_nowb",      0, 0, 0, 0, 1, 0, -1};
        vecs[2] = '{"load",          1, 0, 0, 0, 1, 0, -1};
        vecs[3] = '{"fpu_d4_stray",  0, 1, 0, 0, 4, 1, -1};
        vecs[4] = '{"store_wb",      0, 0, 1, 1, 1, 0, -1};
        vecs[5] = '{"store_load",    1, 0, 1, 0, 1, 0, -1};
        vecs[6] = '{"fpu_store",     0, 1, 1, 1, 2, 0, -1};
        vecs[7] = '{"halt_in_load",  1, 0, 0, 1, 1, 0, FETCH_LAT + 2};
        vecs[8] = '{"halt_in_store", 0, 0, 1, 0, 1, 0, FETCH_LAT + 1};
        vecs[9] = '{"halt_in_exec",  0, 1, 0, 1, 1, 1, FETCH_LAT};

        repeat (2) tick();
        check("reset outputs", 64'(reset_view()), 64'd0);
        rstn = 1'b1;
        tick();
        check("idle hold", 64'({state, busy}), 64'({3'(S_IDLE), 1'b0}));
        run = 1'b1;
        tick();

        c0 = cycles;
        for (int k = 0; k < 10; k++) run_instr($sformatf("thru%0d", k), 0, 0, 0, 1, 1, 0, -1, 0);
        check("throughput cycles", 64'(cycles - c0), 64'(10 * (FETCH_LAT + 2)));

        foreach (vecs[k])
            run_instr(vecs[k].name, vecs[k].ld, vecs[k].fp, vecs[k].st, vecs[k].wb,
                      vecs[k].dly, vecs[k].stray, vecs[k].halt_at, 0);

        for (int k = 0; k < 40; k++) begin
            r_ld   = ($urandom_range(0, 2) == 0);
            r_fp   = ($urandom_range(0, 2) == 0);
            r_st   = ($urandom_range(0, 2) == 0);
            r_wb   = 1'($urandom_range(0, 1));
            r_dly  = int'($urandom_range(1, 6));
            r_halt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_instr($sformatf("rnd%0d", k), r_ld, r_fp, r_st, r_wb, r_dly, 1'($urandom_range(0, 1)), r_halt, 0);
        end

        // Asynchronous reset in the middle of an FPU wait.
        ex_fpu = 1'b1;
        repeat (FETCH_LAT + 1) tick();
        check("pre-reset fpu entry", 64'({state, fpu_start}), 64'({3'(S_FPU), 1'b1}));
        ex_fpu = 1'b0;
        tick();
        #3 rstn = 1'b0;
        #1;
        check("async reset mid-fpu", 64'(reset_view()), 64'd0);
        tick();
        check("reset held over edge", 64'(reset_view()), 64'd0);
        #2 rstn = 1'b1;
        exp_cnt = '0; exp_err = 1'b0; exp_sel = 2'd0;
        tick();
        check("restart fetch", 64'(state), 64'(S_FETCH));
        run_instr("post_reset_load", 1, 0, 0, 0, 1, 0, -1, 0);

`ifdef SEQ_FPU_TIMEOUT_EN
        run_instr("fpu_timeout", 0, 1, 0, 1, 0, 0, -1, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
